// File: rtl/hex_display_scan.sv
// Four-digit hex scanner for a common-anode seven-segment display.
// Latches the value once per frame and flashes the rightmost decimal point after a terminal-count strobe.
module hex_display_scan #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned FLASH_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] val,
    input  logic        term,
    input  logic        lzb,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [1:0]    idx;
    logic [15:0]   disp_latch;
    logic [7:0]    flash_cnt;

    logic          tick;
    logic          frame_end;
    logic [1:0]    idx_nxt;
    logic [15:0]   latch_nxt;
    logic [7:0]    flash_nxt;
    logic [3:0]    nib;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // Next-state and next-output computation; outputs reflect the slot entered on this tick.
    always_comb begin
        tick      = (prescaler == PW'(REFRESH_DIV - 1));
        frame_end = tick && (idx == 2'd3);
        idx_nxt   = tick ? idx + 2'd1 : idx;
        latch_nxt = frame_end ? val : disp_latch;

        flash_nxt = flash_cnt;
        if (term)
            flash_nxt = 8'(FLASH_FRAMES);
        else if (frame_end && (flash_cnt != 8'd0))
            flash_nxt = flash_cnt - 8'd1;

        nib   = latch_nxt[3:0];
        blank = 1'b0;
        case (idx_nxt)
            2'd0: begin
                nib   = latch_nxt[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = latch_nxt[7:4];
                blank = lzb && (latch_nxt[15:4] == 12'd0);
            end
            2'd2: begin
                nib   = latch_nxt[11:8];
                blank = lzb && (latch_nxt[15:8] == 8'd0);
            end
            default: begin
                nib   = latch_nxt[15:12];
                blank = lzb && (latch_nxt[15:12] == 4'd0);
            end
        endcase

        an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
        seg_nxt = blank ? 7'b1111111 : hex7(nib);
        dp_nxt  = !((idx_nxt == 2'd0) && (flash_cnt != 8'd0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= 2'd0;
            disp_latch <= 16'd0;
            flash_cnt  <= 8'd0;
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
        end else begin
            prescaler  <= tick ? '0 : prescaler + PW'(1);
            idx        <= idx_nxt;
            disp_latch <= latch_nxt;
            flash_cnt  <= flash_nxt;
            if (tick) begin
                an  <= an_nxt;
                seg <= seg_nxt;
                dp  <= dp_nxt;
            end
        end
    end

endmodule
